mem_sp_clr: RTL
===============

# mem_sp_clr

Parametrised single-port synchronous memory with a request/response handshake, byte-enabled writes, registered reads and a sequential hardware clear engine. Next-generation replacement for the fixed 8-bit scratch memory in the datapath. Clear runs automatically after reset and on demand, one word per cycle, so it maps onto real block RAM without a single-cycle array reset.

## Interface
Parameters:
- DATA_W, 8: word width in bits; must be a multiple of 8.
- DEPTH, 1024: number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH): address width.
- INIT_VAL, 0: value written to every word during clear.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr_req  in  1  start hardware clear; sampled only in IDLE.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_be  in  DATA_W/8  byte enables for writes; ignored for reads.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse: read data valid.
- rsp_rdata  out  DATA_W  read data.
- rsp_err  out  1  qualifies rsp_valid: read address was out of range.
- busy  out  1  clear in progress.

## Operation
- States: CLEAR, IDLE. Reset forces CLEAR with clear pointer 0.
- CLEAR: each cycle write INIT_VAL to mem[ptr], ptr++; after writing DEPTH-1 go to IDLE. req_ready=0, busy=1.
- IDLE: req_ready=1, busy=0. Handshake = req_valid && req_ready at a rising edge.
- Write accepted: for each byte b with req_be[b]=1, mem[addr] byte b <= req_wdata byte b; other bytes keep value. No response.
- Read accepted: rsp_valid=1 next cycle with rsp_rdata=mem[addr]; rsp_err=0.
- Out of range (req_addr >= DEPTH): write dropped, memory unchanged; read returns rsp_valid=1, rsp_rdata=0, rsp_err=1.
- clr_req=1 at an IDLE edge: go to CLEAR, ptr=0. If a request handshakes at the same edge, it executes first (read still responds next cycle); clear follows.
- clr_req ignored in CLEAR; no queuing.
- rsp_rdata holds its last value when rsp_valid=0; rsp_err is 0 whenever rsp_valid=0.
- req_ready, busy, rsp_* are registered outputs (no combinational path from inputs).

## Timing
- Reset values: req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=CLEAR, ptr=0. Memory contents undefined until clear completes.
- Clear duration: exactly DEPTH cycles. With the last rst-high edge at E0, addresses 0..DEPTH-1 are written at edges E1..E_DEPTH; req_ready=1 and busy=0 from the cycle after E_DEPTH.
- Same for clr_req: accepted at edge E0, req_ready=0 from the next cycle, IDLE again after DEPTH write edges.
- Read latency 1: handshake at edge N, rsp_valid high for one cycle after N.
- Back-to-back requests accepted every cycle in IDLE; read-after-write to same address on the next cycle returns the new data.
- Reset mid-clear or mid-access: restarts clear at ptr=0. A pending rsp_valid is cancelled. Memory is fully cleared again.
- rst has priority over clr_req and requests.

## Test plan
- Reset, DEPTH=16: busy=1/req_ready=0 for 16 cycles after rst drops, then ready. Read all 16 addresses -> every rsp_rdata=INIT_VAL, rsp_err=0.
- DATA_W=32: write 0xAABBCCDD be=4'b1111 to addr 3, then 0x11223344 be=4'b0101 -> read addr 3 returns 0xAA22CC44 one cycle after handshake.
- Back-to-back: write 0x5A to addr 7 at edge N, read addr 7 at edge N+1 -> rsp_valid at N+2 with 0x5A. Continuous reads of 0..15 every cycle -> 16 consecutive rsp_valid pulses, in order.
- DEPTH=12: write addr 13 then read addr 13 -> rsp_err=1, rsp_rdata=0. Read addr 11 is unaffected.
- clr_req with simultaneous read of addr 2 (holding 0x77) -> response 0x77 next cycle, then req_ready=0 for 16 cycles, then addr 2 reads INIT_VAL.
- Assert rst for 1 cycle at clear cycle 5 -> clear restarts, and a full DEPTH cycles elapse before req_ready=1.

Source files
------------

// File: rtl/mem_sp_clr.sv
// mem_sp_clr: single-port synchronous memory with a request/response handshake,
// byte-enabled writes, registered reads and a sequential one-word-per-cycle clear engine.
`default_nettype none

module mem_sp_clr #(
  parameter int unsigned          DATA_W   = 8,
  parameter int unsigned          DEPTH    = 1024,
  parameter int unsigned          ADDR_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0]    INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned       NBYTES    = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                w_hs;
  logic                w_in_range;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [NBYTES-1:0]   w_mem_be;
  logic                w_rd_en;

  assign w_hs       = (state_q == ST_IDLE) && req_valid;
  assign w_in_range = {1'b0, req_addr} < DEPTH_X;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    w_mem_we    = 1'b0;
    w_mem_addr  = req_addr;
    w_mem_wdata = req_wdata;
    w_mem_be    = req_be;
    w_rd_en     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = ptr_q;
        w_mem_wdata = INIT_VAL;
        w_mem_be    = '1;
        ptr_d       = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      ST_IDLE: begin
        // A request taken at the same edge as clr_req still executes.
        if (w_hs) begin
          if (req_we) begin
            w_mem_we = w_in_range;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = ~w_in_range;
            w_rd_en     = w_in_range;
          end
        end
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (w_mem_be[b]) begin
          mem[w_mem_addr][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read data register holds its value between responses; out-of-range reads return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      if (w_rd_en) begin
        rsp_rdata_q <= mem[req_addr];
      end else if (rsp_err_d) begin
        rsp_rdata_q <= '0;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

`default_nettype wire
